// File: rtl/emu_scan_pkg.sv
// rtl/emu_scan_pkg.sv - shared FSM type and constants for the emulation scan RAM
package emu_scan_pkg;

   localparam int SCAN_W_DEF = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DUMP = 2'd1,
      ST_LOAD = 2'd2,
      ST_DONE = 2'd3
   } scan_state_e;

   // Number of scan words needed to carry one memory entry.
   function automatic int scan_chunks(input int width, input int scan_w);
      return (width + scan_w - 1) / scan_w;
   endfunction

endpackage

// File: rtl/emu_scan_ram_if.sv
// rtl/emu_scan_ram_if.sv - functional and scan port bundle of the emulation scan RAM
interface emu_scan_ram_if #(
   parameter int DEPTH  = 64,
   parameter int WIDTH  = 80,
   parameter int SCAN_W = emu_scan_pkg::SCAN_W_DEF
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic              halt;
   logic              scan;
   logic              dir;
   logic [SCAN_W-1:0] sdi;
   logic [SCAN_W-1:0] sdo;
   logic [AW-1:0]     raddr;
   logic [AW-1:0]     waddr;
   logic              wen;
   logic [WIDTH-1:0]  wdata;
   logic [WIDTH-1:0]  rdata;

   modport master (
      output halt, scan, dir, sdi, raddr, waddr, wen, wdata,
      input  sdo, rdata
   );

   modport slave (
      input  halt, scan, dir, sdi, raddr, waddr, wen, wdata,
      output sdo, rdata
   );

endinterface

// File: rtl/emu_scan_ram_core.sv
// rtl/emu_scan_ram_core.sv - DEPTH x WIDTH storage with one synchronous read port and one muxed write port
module emu_scan_ram_core #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 80,
   parameter int AW    = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             scan_sel_i,
   input  logic [AW-1:0]    func_raddr_i,
   input  logic             func_we_i,
   input  logic [AW-1:0]    func_waddr_i,
   input  logic [WIDTH-1:0] func_wdata_i,
   input  logic [AW-1:0]    scan_raddr_i,
   input  logic             scan_we_i,
   input  logic [AW-1:0]    scan_waddr_i,
   input  logic [WIDTH-1:0] scan_wdata_i,
   output logic [WIDTH-1:0] rd_data_o
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic             we;
   logic [AW-1:0]    wa;
   logic [AW-1:0]    ra;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] rd_q;

   // Port muxing: a scan write always wins over a functional write.
   always_comb begin
      we = scan_we_i | func_we_i;
      wa = scan_we_i ? scan_waddr_i : func_waddr_i;
      wd = scan_we_i ? scan_wdata_i : func_wdata_i;
      ra = scan_sel_i ? scan_raddr_i : func_raddr_i;
   end

   // Storage array; contents deliberately survive reset.
   always_ff @(posedge clk_i) begin
      if (we) begin
         mem[wa] <= wd;
      end
   end

   // Registered read returns the pre-write value on an address collision.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_q <= '0;
      end else begin
         rd_q <= mem[ra];
      end
   end

   assign rd_data_o = rd_q;

endmodule

// File: rtl/emu_scan_ram.sv
// rtl/emu_scan_ram.sv - emulation RAM with halt-time scan dump/restore of its full contents
module emu_scan_ram
   import emu_scan_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int WIDTH  = 80,
   parameter int SCAN_W = SCAN_W_DEF
) (
   input  logic          clk,
   input  logic          rst,
   emu_scan_ram_if.slave bus
);

   localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CHUNKS = scan_chunks(WIDTH, SCAN_W);
   localparam int TOTAL  = DEPTH * CHUNKS;
   localparam int PW     = $clog2(TOTAL + 1);
   localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam int PADW   = CHUNKS * SCAN_W;

   scan_state_e       state_q, state_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [AW-1:0]     ent_q, ent_d;
   logic [CW-1:0]     chk_q, chk_d;
   logic [SCAN_W-1:0] sdo_q, sdo_d;
   logic [PADW-1:0]   asm_q, asm_d;
   logic [WIDTH-1:0]  hold_q, hold_d;
   logic              func_q, func_d;

   logic [PADW-1:0]   asm_ins;
   logic [PADW-1:0]   rd_pad;
   logic [SCAN_W-1:0] rd_word;
   logic [WIDTH-1:0]  core_rd;
   logic [WIDTH-1:0]  rdata_view;

   logic              scan_act;
   logic              last_word;
   logic              last_chunk;
   logic              dump_en;
   logic              load_en;
   logic              done_en;
   logic              step;
   logic              scan_we;

   // Scan is only honoured while halted; otherwise everything falls back to IDLE.
   assign scan_act   = bus.scan & bus.halt;
   assign last_word  = (ptr_q == PW'(TOTAL - 1));
   assign last_chunk = (chk_q == CW'(CHUNKS - 1));

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; direction is latched by leaving IDLE.
   always_comb begin
      state_d = state_q;
      if (!scan_act) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (last_word)    state_d = ST_DONE;
               else if (bus.dir) state_d = ST_LOAD;
               else              state_d = ST_DUMP;
            end
            ST_DUMP, ST_LOAD: begin
               if (last_word) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // FSM outputs; the IDLE->DUMP/LOAD edge already transfers word 0.
   always_comb begin
      dump_en = scan_act && ((state_q == ST_IDLE && !bus.dir) || state_q == ST_DUMP);
      load_en = scan_act && ((state_q == ST_IDLE &&  bus.dir) || state_q == ST_LOAD);
      done_en = scan_act && (state_q == ST_DONE);
      step    = dump_en | load_en;
      scan_we = load_en & last_chunk;
   end

   // Word pointer split into entry/chunk counters; ent_d drives the prefetch address.
   always_comb begin
      ptr_d = ptr_q;
      ent_d = ent_q;
      chk_d = chk_q;
      if (!scan_act) begin
         ptr_d = '0;
         ent_d = '0;
         chk_d = '0;
      end else if (step) begin
         ptr_d = ptr_q + 1'b1;
         if (last_chunk) begin
            chk_d = '0;
            ent_d = last_word ? '0 : ent_q + 1'b1;
         end else begin
            chk_d = chk_q + 1'b1;
         end
      end
   end

   // Scan data path: chunk select for dump, chunk insert for restore.
   always_comb begin
      rd_pad              = '0;
      rd_pad[WIDTH-1:0]   = core_rd;
      rd_word             = rd_pad[int'(chk_q)*SCAN_W +: SCAN_W];
      asm_ins             = asm_q;
      asm_ins[int'(chk_q)*SCAN_W +: SCAN_W] = bus.sdi;
      sdo_d = sdo_q;
      if (dump_en)      sdo_d = rd_word;
      else if (done_en) sdo_d = '0;
      asm_d = asm_q;
      if (!scan_act)    asm_d = '0;
      else if (load_en) asm_d = asm_ins;
   end

   // Functional read view: live read data while running, frozen copy while halted.
   always_comb begin
      rdata_view = func_q ? core_rd : hold_q;
      hold_d     = rdata_view;
      func_d     = ~bus.halt;
   end

   // Data path registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q  <= '0;
         ent_q  <= '0;
         chk_q  <= '0;
         sdo_q  <= '0;
         asm_q  <= '0;
         hold_q <= '0;
         func_q <= 1'b1;
      end else begin
         ptr_q  <= ptr_d;
         ent_q  <= ent_d;
         chk_q  <= chk_d;
         sdo_q  <= sdo_d;
         asm_q  <= asm_d;
         hold_q <= hold_d;
         func_q <= func_d;
      end
   end

   emu_scan_ram_core #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .AW    (AW)
   ) u_core (
      .clk_i        (clk),
      .rst_i        (rst),
      .scan_sel_i   (bus.halt),
      .func_raddr_i (bus.raddr),
      .func_we_i    (bus.wen & ~bus.halt),
      .func_waddr_i (bus.waddr),
      .func_wdata_i (bus.wdata),
      .scan_raddr_i (ent_d),
      .scan_we_i    (scan_we),
      .scan_waddr_i (ent_q),
      .scan_wdata_i (asm_ins[WIDTH-1:0]),
      .rd_data_o    (core_rd)
   );

   assign bus.sdo   = sdo_q;
   assign bus.rdata = rdata_view;

endmodule

// File: tb/tb_emu_scan_ram.sv
// tb/tb_emu_scan_ram.sv - randomized self-checking bench for emu_scan_ram
module tb_emu_scan_ram;

   localparam int DEPTH  = 64;
   localparam int WIDTH  = 80;
   localparam int SCAN_W = 64;
   localparam int TOTAL  = 128;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [WIDTH-1:0]  m      [DEPTH];
   logic [WIDTH-1:0]  snap   [DEPTH];
   logic [WIDTH-1:0]  rounds [4][DEPTH];
   logic [SCAN_W-1:0] words  [TOTAL];
   logic [SCAN_W-1:0] rwords [4][TOTAL];
   logic [WIDTH-1:0]  pre;

   emu_scan_ram_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SCAN_W(SCAN_W)) bus ();

   emu_scan_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SCAN_W(SCAN_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic expect_eq(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WIDTH-1:0] rand_entry();
      logic [WIDTH-1:0] v;
      v[31:0]  = $urandom;
      v[63:32] = $urandom;
      v[79:64] = 16'($urandom);
      return v;
   endfunction

   // Scan image of the reference memory: low 64 bits, then the top 16 zero-padded.
   function automatic logic [SCAN_W-1:0] model_word(input int k);
      logic [WIDTH-1:0] e;
      e = m[k / 2];
      if (k % 2 == 0) return e[63:0];
      return {48'h0, e[79:64]};
   endfunction

   task automatic write_random();
      bus.halt = 1'b0;
      bus.scan = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         m[i]      = rand_entry();
         bus.wen   = 1'b1;
         bus.waddr = 6'(i);
         bus.wdata = m[i];
         tick();
      end
      bus.wen = 1'b0;
   endtask

   task automatic read_all(input string tag);
      bus.halt = 1'b0;
      bus.scan = 1'b0;
      for (int a = 0; a < DEPTH; a++) begin
         bus.raddr = 6'(a);
         tick();
         expect_eq($sformatf("%s_rd%0d", tag, a), bus.rdata, m[a]);
      end
   endtask

   task automatic enter_halt();
      bus.halt = 1'b1;
      bus.scan = 1'b0;
      tick();
      tick();
   endtask

   // Dump n words, checking each and keeping the model image in words[].
   task automatic dump(input string tag, input int n, input bit drop);
      bus.scan = 1'b1;
      for (int k = 0; k < n; k++) begin
         bus.dir = (k == 0) ? 1'b0 : 1'($urandom);
         tick();
         expect_eq($sformatf("%s_w%0d", tag, k), {16'h0, bus.sdo}, {16'h0, model_word(k)});
         words[k] = model_word(k);
      end
      if (drop) begin
         bus.scan = 1'b0;
         tick();
      end
   endtask

   // Restore the first n entries of words[]; optionally drive one surplus word.
   task automatic restore(input int n, input bit extra);
      bus.scan = 1'b1;
      for (int k = 0; k < n; k++) begin
         bus.dir = (k == 0) ? 1'b1 : 1'($urandom);
         bus.sdi = words[k];
         tick();
      end
      if (extra) begin
         bus.sdi = {$urandom, $urandom};
         bus.dir = 1'($urandom);
         tick();
         expect_eq("done_sdo_zero", {16'h0, bus.sdo}, '0);
      end
      bus.scan = 1'b0;
      tick();
   endtask

   initial begin
      rst       = 1'b1;
      bus.halt  = 1'b0;
      bus.scan  = 1'b0;
      bus.dir   = 1'b0;
      bus.sdi   = '0;
      bus.raddr = '0;
      bus.waddr = '0;
      bus.wen   = 1'b0;
      bus.wdata = '0;
      tick();
      tick();
      expect_eq("reset_sdo", {16'h0, bus.sdo}, '0);
      expect_eq("reset_rdata", bus.rdata, '0);
      rst = 1'b0;
      tick();

      write_random();
      read_all("func");

      // Same-address read and write: old value first, new value next cycle.
      bus.raddr = 6'd5;
      bus.waddr = 6'd5;
      bus.wdata = rand_entry();
      bus.wen   = 1'b1;
      tick();
      bus.wen = 1'b0;
      expect_eq("rbw_old", bus.rdata, m[5]);
      m[5] = bus.wdata;
      tick();
      expect_eq("rbw_new", bus.rdata, m[5]);

      // rdata freezes across halt; wen while halted is ignored.
      bus.raddr = 6'd7;
      tick();
      pre = m[7];
      expect_eq("pre_halt_rdata", bus.rdata, pre);
      bus.halt  = 1'b1;
      tick();
      bus.waddr = 6'd3;
      bus.wdata = rand_entry();
      bus.wen   = 1'b1;
      bus.raddr = 6'd9;
      tick();
      tick();
      bus.wen = 1'b0;
      expect_eq("halt_hold_rdata", bus.rdata, pre);
      tick();

      dump("dump1", TOTAL, 1'b1);
      expect_eq("halt_hold_after_dump", bus.rdata, pre);

      // Scan without halt does nothing.
      bus.halt = 1'b0;
      bus.scan = 1'b1;
      bus.dir  = 1'b0;
      repeat (3) tick();
      expect_eq("illegal_scan_sdo", {16'h0, bus.sdo}, {16'h0, model_word(TOTAL - 1)});
      bus.scan = 1'b0;

      // Full restore of a saved image with a surplus 129th word.
      for (int i = 0; i < DEPTH; i++) snap[i] = m[i];
      for (int k = 0; k < TOTAL; k++) rwords[0][k] = model_word(k);
      write_random();
      enter_halt();
      for (int k = 0; k < TOTAL; k++) words[k] = rwords[0][k];
      restore(TOTAL, 1'b1);
      for (int i = 0; i < DEPTH; i++) m[i] = snap[i];
      read_all("restore");

      // Four dump rounds, then four restores in the same order.
      for (int r = 0; r < 4; r++) begin
         write_random();
         for (int i = 0; i < DEPTH; i++) rounds[r][i] = m[i];
         enter_halt();
         dump($sformatf("round%0d", r), TOTAL, 1'b1);
         for (int k = 0; k < TOTAL; k++) rwords[r][k] = words[k];
      end
      for (int r = 0; r < 4; r++) begin
         enter_halt();
         for (int k = 0; k < TOTAL; k++) words[k] = rwords[r][k];
         restore(TOTAL, 1'b0);
         for (int i = 0; i < DEPTH; i++) m[i] = rounds[r][i];
         read_all($sformatf("rest%0d", r));
      end

      // Partial restore of five words: entries 0 and 1 only.
      enter_halt();
      for (int k = 0; k < 5; k++) words[k] = {$urandom, $urandom};
      restore(5, 1'b0);
      m[0] = {words[1][15:0], words[0]};
      m[1] = {words[3][15:0], words[2]};
      dump("partial", TOTAL, 1'b1);
      read_all("partial");

      // Reset in the middle of a dump.
      enter_halt();
      dump("pre_rst", 40, 1'b0);
      #2 rst = 1'b1;
      #1;
      expect_eq("midscan_rst_sdo", {16'h0, bus.sdo}, '0);
      bus.scan = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      tick();
      dump("post_rst", TOTAL, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/emu_scan_ram.md
EMU_SCAN_RAM -- requirements
Module: emu_scan_ram

Interface
REQ-001 SHALL have parameter DEPTH, default 64: number of memory entries.
REQ-002 SHALL have parameter WIDTH, default 80: bits per entry.
REQ-003 SHALL have parameter SCAN_W, default 64: scan word width.
REQ-004 SHALL have input clk, 1 bit: the only clock; all state changes on rising edge.
REQ-005 SHALL have input rst, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have input halt, 1 bit: emulation halt; high freezes the functional port.
REQ-007 SHALL have input scan, 1 bit: scan enable; one scan word transferred per cycle while high.
REQ-008 SHALL have input dir, 1 bit: 0 = dump (memory to sdo), 1 = restore (sdi to memory).
REQ-009 SHALL have input sdi, SCAN_W bits: restore data word.
REQ-010 SHALL have output sdo, SCAN_W bits: dump data word, registered.
REQ-011 SHALL have inputs raddr and waddr, clog2(DEPTH) bits each: functional read and write addresses.
REQ-012 SHALL have input wen, 1 bit, and input wdata, WIDTH bits: functional write.
REQ-013 SHALL have output rdata, WIDTH bits: functional read data, registered.

Function
REQ-014 SHALL derive CHUNKS = ceil(WIDTH/SCAN_W) (2 at defaults) and TOTAL = DEPTH*CHUNKS (128).
REQ-015 SHALL serialise entry e as words e*CHUNKS..e*CHUNKS+CHUNKS-1, low bits first, with the top word zero-padded above WIDTH.
REQ-016 SHALL, while halt=0, write wdata to mem[waddr] on wen and register mem[raddr] into rdata each cycle (1-cycle latency, read-before-write on the same address).
REQ-017 SHALL ignore wen and hold rdata while halt=1.
REQ-018 SHALL run an FSM with states IDLE, DUMP, LOAD and DONE, plus a word counter ptr (0..TOTAL).
REQ-019 In IDLE with halt=1 and scan=0, SHALL hold ptr=0 and keep word 0 prefetched.
REQ-020 On scan=1 in IDLE, SHALL go to DUMP if dir=0 or LOAD if dir=1.
REQ-021 In DUMP, SHALL, at each edge with scan=1, load sdo with word ptr and increment ptr, so sdo holds word k after the (k+1)-th scan edge.
REQ-022 In LOAD, SHALL, at each edge with scan=1, capture sdi as word ptr and increment ptr; on the last chunk of an entry, SHALL write the assembled WIDTH bits (padding discarded) to that entry.
REQ-023 SHALL go to DONE when ptr reaches TOTAL; in DONE, further scan cycles SHALL drive sdo=0 and ignore sdi, with no memory write.
REQ-024 SHALL return to IDLE with ptr=0 from any state when scan=0; a partially assembled restore entry SHALL be discarded.
REQ-025 SHALL ignore a dir change while scan=1 until the next return to IDLE.
REQ-026 SHALL treat scan=1 with halt=0 as illegal: the FSM stays in IDLE and memory is untouched.
REQ-027 SHALL make scan writes take priority over functional writes; these are exclusive by REQ-017.

Reset
REQ-028 SHALL, on rst, asynchronously set the FSM to IDLE, ptr=0, sdo=0, rdata=0 and clear the restore assembly register.
REQ-029 SHALL NOT clear memory contents on reset.
REQ-030 SHALL abort a scan in progress when rst asserts mid-scan, leaving already-written entries intact.

Structure
REQ-031 SHALL place the FSM state enum and a SCAN_W default constant in shared package emu_scan_pkg.
REQ-032 SHALL instantiate one sub-module, emu_scan_ram_core: a DEPTH x WIDTH memory with one synchronous read port and one write port, muxed between the functional and scan paths.

Verification
REQ-033 Write 64 random 80-bit entries, halt, dump 128 words -> word 2e equals entry e bits [63:0]; word 2e+1 equals {48'h0, entry e bits [79:64]}.
REQ-034 Restore 128 saved words, hold scan for a 129th cycle, unhalt, read all 64 addresses -> rdata matches the saved entries; the 129th word is ignored.
REQ-035 Run 4 dump rounds with distinct data, then 4 restores -> every round reproduces its own data exactly.
REQ-036 Drop scan after 5 restore words -> entries 0 and 1 are updated, entry 2 is unchanged, and the next scan starts at ptr 0.
REQ-037 Assert rst at dump word 40 -> sdo=0 and the FSM is IDLE; a fresh dump returns word 0 first with memory unchanged.
REQ-038 Pulse wen while halt=1 -> memory is unchanged; rdata holds its pre-halt value.
